stage_decode: RTL
=================

# stage_decode

RV32I decode stage sitting directly downstream of the fetch stage, consuming its instruction stream over a valid/ready pipeline handshake. Splits each instruction word into register indices, function fields, a sign-extended immediate, an instruction class and an illegal flag. Tracks the PC of each instruction locally, because fetch delivers bare instruction words. Holds two entries, an output register plus a skid register, so the output can be fully registered and still sustain one instruction per cycle. Honours pipeline flush with the same semantics as fetch.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_flush  in  1  redirect; same signal that drives fetch
- pc_new  in  32  PC of the first instruction after redirect
- up_valid  in  1  instruction word valid from fetch
- up_ready  out  1  stage can accept a word
- up_instr  in  32  instruction word
- dn_valid  out  1  decoded entry valid
- dn_ready  in  1  consumer accepts entry
- dn_pc  out  32  PC of the entry
- dn_instr  out  32  raw instruction word
- dn_class  out  4  0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 MISC_MEM, 11 SYSTEM
- dn_rd, dn_rs1, dn_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20], always passed through raw
- dn_funct3  out  3  instr[14:12]
- dn_alt  out  1  instr[30]; meaningful for OP, and for OP_IMM shifts
- dn_imm  out  32  sign-extended immediate per class; 0 for OP, MISC_MEM, ILLEGAL
- dn_illegal  out  1  1 exactly when dn_class is 0

## Operation
- **Handshakes.** Up handshake occurs when up_valid && up_ready. Down handshake occurs when dn_valid && dn_ready.
- **Legality.** An instruction is legal only if instr[1:0] == 11 and one of these holds:
  - LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - JALR 1100111 with funct3 0.
  - BRANCH 1100011 with funct3 not 2 or 3.
  - LOAD 0000011 with funct3 in {0,1,2,4,5}.
  - STORE 0100011 with funct3 in {0,1,2}.
  - OP_IMM 0010011: funct3 1 needs instr[31:25] == 0; funct3 5 needs instr[31:25] in {0, 0100000}.
  - OP 0110011: instr[31:25] == 0 for any funct3, or 0100000 for funct3 0 or 5.
  - MISC_MEM 0001111 or SYSTEM 1110011, any other bits.
- **Illegal words.** Everything else gets class 0, dn_illegal 1 and imm 0. The entry is still forwarded.
- **Immediates.** Sign bit is always instr[31].
  - I format: JALR, LOAD, OP_IMM, SYSTEM.
  - S format: STORE.
  - B format: BRANCH, with bit 0 = 0.
  - U format: LUI, AUIPC, with instr[31:12] << 12.
  - J format: JAL, with bit 0 = 0.
- **Where decode happens.** Decode is combinational on up_instr. Results are captured into an entry at the up handshake.
- **Entries.** Two entries: OUT, which drives the dn_* outputs, and SKID.
- **up_ready.** up_ready = !skid_valid && !rst.
- **Entry movement, when no flush:**
  - Up beat, OUT empty or draining this cycle: the beat loads OUT.
  - Up beat, OUT full and not draining: the beat loads SKID.
  - OUT drains while SKID is full: SKID moves to OUT and SKID empties.
- **PC counter.** Register pc, reset value 0.
  - On an up handshake with no flush, the entry takes pc, then pc <= pc + 4 (mod 2^32).
  - On pc_flush, pc <= pc_new, taking priority over the increment.
- **Flush.**
  - In the cycle pc_flush is high, any up beat accepted that cycle is dropped.
  - Next cycle, both entries are empty.
  - A down handshake in the flush cycle counts as delivered.
  - The first word accepted after the flush gets dn_pc = pc_new.

## Timing
- **Reset values.** While rst is high and in the first cycle after, dn_valid = 0 and all dn_* data = 0. up_ready = 0 while rst is high and 1 in the first cycle after rst falls. pc = 0.
- **Latency.** An up handshake in cycle N gives dn_valid in N+1 if OUT was empty or draining at N.
- **Throughput.** One instruction per cycle while dn_ready is held high.
- **Output stability.** dn_* outputs come from registers only. They are stable while dn_valid && !dn_ready.
- **Backpressure.** dn_ready low for k ≥ 1 cycles with continuous up_valid: exactly one extra word is absorbed into SKID, then up_ready = 0. No word is lost or duplicated.
- **up_ready timing.** up_ready depends only on registered state. It rises in the cycle after SKID drains.
- **Flush with both entries full.** Both entries are cleared, and up_ready = 1 next cycle.
- **Reset mid-operation.** Same as the flush case, and pc returns to 0.

## Test plan
- **Reset.** Hold rst 3 cycles, then release. Check dn_valid = 0, up_ready = 0 during rst and 1 after. Feed 0x00500093 (addi x1,x0,5): dn_pc 0, class 8, rd 1, rs1 0, imm 5, one cycle later.
- **Streaming.** Push 0x00000013 ×4 back-to-back with dn_ready = 1. Check dn_pc 0,4,8,12 on consecutive cycles, no bubbles.
- **Backpressure.** Drop dn_ready for 3 cycles mid-stream. Check up_ready = 0 after one extra accept. After release, words emerge in order with no loss.
- **Immediates.** Check each of the following:
  - 0xFE000EE3 (beq, offset −4): class 5, imm 0xFFFFFFFC.
  - 0x800000EF (jal, −1 MiB): imm 0xFFF00000.
  - 0x12345037 (lui): imm 0x12345000.
  - 0xFE112E23 (sw, −4): class 7, imm 0xFFFFFFFC.
- **Illegal.** Check each of the following gives class 0, dn_illegal 1, imm 0:
  - 0x00000000.
  - 0x0000200F... no: 0x0000206B (reserved opcode).
  - 0x40001013 (slli with alt set).
  - 0x02000033 (mul, funct7 1).
- **Flush.**
  - Setup: both entries full and an up beat in the flush cycle. Pulse pc_flush with pc_new 0x80000100.
  - Check: next cycle dn_valid = 0 and the beat is dropped.
  - Check: the next word carries dn_pc 0x80000100, and the following one 0x80000104.

Source files
------------

// File: rtl/stage_decode.sv
// RV32I decode stage: splits fetch words into fields, tracks PC locally, 1-cycle latency.
// OUT + SKID entries keep dn_* registered at full rate; up_ready drops only while SKID is full.
module stage_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_flush,
  input  logic [31:0] pc_new,
  input  logic        up_valid,
  output logic        up_ready,
  input  logic [31:0] up_instr,
  output logic        dn_valid,
  input  logic        dn_ready,
  output logic [31:0] dn_pc,
  output logic [31:0] dn_instr,
  output logic [3:0]  dn_class,
  output logic [4:0]  dn_rd,
  output logic [4:0]  dn_rs1,
  output logic [4:0]  dn_rs2,
  output logic [2:0]  dn_funct3,
  output logic        dn_alt,
  output logic [31:0] dn_imm,
  output logic        dn_illegal
);

  localparam logic [3:0] C_ILLEGAL = 4'd0,  C_LUI    = 4'd1,  C_AUIPC  = 4'd2,
                         C_JAL     = 4'd3,  C_JALR   = 4'd4,  C_BRANCH = 4'd5,
                         C_LOAD    = 4'd6,  C_STORE  = 4'd7,  C_OP_IMM = 4'd8,
                         C_OP      = 4'd9,  C_MISC   = 4'd10, C_SYSTEM = 4'd11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [3:0]  cls_c;
  logic [31:0] imm_c;
  logic [31:0] sx;

  assign opc = up_instr[6:0];
  assign f3  = up_instr[14:12];
  assign f7  = up_instr[31:25];
  assign sx  = {32{up_instr[31]}};

  always_comb begin
    cls_c = C_ILLEGAL;
    case (opc)
      7'b0110111: cls_c = C_LUI;
      7'b0010111: cls_c = C_AUIPC;
      7'b1101111: cls_c = C_JAL;
      7'b1100111: if (f3 == 3'd0) cls_c = C_JALR;
      7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) cls_c = C_BRANCH;
      7'b0000011: if (f3 != 3'd3 && f3 <= 3'd5) cls_c = C_LOAD;
      7'b0100011: if (f3 <= 3'd2) cls_c = C_STORE;
      // Only the shift encodings constrain funct7 for OP_IMM.
      7'b0010011: begin
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) cls_c = C_OP_IMM;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00 || f7 == 7'h20) cls_c = C_OP_IMM;
        end else begin
          cls_c = C_OP_IMM;
        end
      end
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) cls_c = C_OP;
      7'b0001111: cls_c = C_MISC;
      7'b1110011: cls_c = C_SYSTEM;
      default: cls_c = C_ILLEGAL;
    endcase
  end

  always_comb begin
    imm_c = '0;
    case (cls_c)
      C_JALR, C_LOAD, C_OP_IMM, C_SYSTEM: imm_c = {sx[31:12], up_instr[31:20]};
      C_STORE:        imm_c = {sx[31:12], up_instr[31:25], up_instr[11:7]};
      C_BRANCH:       imm_c = {sx[31:13], up_instr[31], up_instr[7], up_instr[30:25],
                               up_instr[11:8], 1'b0};
      C_LUI, C_AUIPC: imm_c = {up_instr[31:12], 12'h000};
      C_JAL:          imm_c = {sx[31:21], up_instr[31], up_instr[19:12], up_instr[20],
                               up_instr[30:21], 1'b0};
      default:        imm_c = '0;
    endcase
  end

  entry_t      out_q, out_d, skid_q, skid_d, new_entry;
  logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [31:0] pc_q, pc_d;
  logic        up_fire, dn_fire;

  assign up_ready = !skid_vld_q && !rst;
  assign up_fire  = up_valid && up_ready;
  assign dn_fire  = out_vld_q && dn_ready;

  always_comb begin
    new_entry.pc      = pc_q;
    new_entry.instr   = up_instr;
    new_entry.cls     = cls_c;
    new_entry.imm     = imm_c;
    new_entry.illegal = (cls_c == C_ILLEGAL);
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    pc_d       = pc_q;
    if (pc_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      pc_d       = pc_new;
    end else begin
      if (up_fire) pc_d = pc_q + 32'd4;
      if (!out_vld_q || dn_fire) begin
        // SKID is only ever full while OUT is full, so it never races a new beat.
        if (skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end else if (up_fire) begin
          out_d     = new_entry;
          out_vld_d = 1'b1;
        end else begin
          out_vld_d = 1'b0;
        end
      end else if (up_fire) begin
        skid_d     = new_entry;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      pc_q       <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      pc_q       <= pc_d;
    end
  end

  assign dn_valid   = out_vld_q;
  assign dn_pc      = out_q.pc;
  assign dn_instr   = out_q.instr;
  assign dn_class   = out_q.cls;
  assign dn_rd      = out_q.instr[11:7];
  assign dn_rs1     = out_q.instr[19:15];
  assign dn_rs2     = out_q.instr[24:20];
  assign dn_funct3  = out_q.instr[14:12];
  assign dn_alt     = out_q.instr[30];
  assign dn_imm     = out_q.imm;
  assign dn_illegal = out_q.illegal;

endmodule
